// File: rtl/div_alu_seq.sv
// Multi-cycle radix-2 restoring divider with start/ready handshake.
// Define DIV_ALU_SIGNED_EN to add the signed_in port and two's-complement mode.
module div_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_ALU_SIGNED_EN
  input  logic             signed_in,
`endif
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             dz;
  logic             div_zero;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign div_zero = (divisor_in == '0);
  assign trial    = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
  assign busy     = (state != IDLE);

`ifdef DIV_ALU_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic q_neg;
  logic r_neg;

  assign a_neg = signed_in & dividend_in[WIDTH-1];
  assign b_neg = signed_in & divisor_in[WIDTH-1];
  assign a_mag = a_neg ? -dividend_in : dividend_in;
  assign b_mag = b_neg ? -divisor_in : divisor_in;
  assign q_fix = q_neg ? -quo : quo;
  assign r_fix = r_neg ? -rem : rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
    end
  end
`else
  assign a_mag = dividend_in;
  assign b_mag = divisor_in;
  assign q_fix = quo;
  assign r_fix = rem;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = div_zero ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      dvsr          <= '0;
      dz            <= 1'b0;
      ready         <= 1'b0;
      div_by_zero   <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt         <= CNT_W'(WIDTH);
            rem         <= '0;
            // a zero divisor skips CALC, so quo carries the raw dividend
            quo         <= div_zero ? dividend_in : a_mag;
            dvsr        <= b_mag;
            dz          <= div_zero;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (!trial[WIDTH]) rem <= trial[WIDTH-1:0];
          else               rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        end
        DONE: begin
          ready         <= 1'b1;
          div_by_zero   <= dz;
          quotient_out  <= dz ? '1 : q_fix;
          remainder_out <= dz ? quo : r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_alu_seq.sv
// Directed testbench for div_alu_seq at WIDTH=32 and WIDTH=8.
// Signed vectors run only when DIV_ALU_SIGNED_EN is defined.
module tb_div_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        s32;
  logic [31:0] a32, b32, q32, r32;
  logic        bz32, rd32, dz32;
  logic        s8;
  logic [7:0]  a8, b8, q8, r8;
  logic        bz8, rd8, dz8;
`ifdef DIV_ALU_SIGNED_EN
  logic        sg32;
  logic        sg8;
`endif

  always #5 clk = ~clk;

  div_alu_seq #(.WIDTH(32)) u32 (
    .clk(clk),
    .reset(reset),
    .start(s32),
`ifdef DIV_ALU_SIGNED_EN
    .signed_in(sg32),
`endif
    .dividend_in(a32),
    .divisor_in(b32),
    .busy(bz32),
    .ready(rd32),
    .quotient_out(q32),
    .remainder_out(r32),
    .div_by_zero(dz32)
  );

  div_alu_seq #(.WIDTH(8)) u8 (
    .clk(clk),
    .reset(reset),
    .start(s8),
`ifdef DIV_ALU_SIGNED_EN
    .signed_in(sg8),
`endif
    .dividend_in(a8),
    .divisor_in(b8),
    .busy(bz8),
    .ready(rd8),
    .quotient_out(q8),
    .remainder_out(r8),
    .div_by_zero(dz8)
  );

  task automatic do_div32(input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [31:0] eq,
                          input logic [31:0] er, input logic edz,
                          input string nm);
    int lat;
    s32 = 1'b1;
    a32 = a;
    b32 = b;
`ifdef DIV_ALU_SIGNED_EN
    sg32 = sg;
`endif
    @(posedge clk); #1;
    s32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    n_chk++;
    if (bz32 !== 1'b1 || rd32 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b ready=%b expected 1 0", nm, bz32, rd32);
    end
    lat = (b == 32'd0) ? 1 : 33;
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
    end
    if (lat > 1) begin
      n_chk++;
      if (rd32 !== 1'b0) begin
        n_fail++;
        $display("FAIL %s early: ready=%b expected 0", nm, rd32);
      end
    end
    @(posedge clk); #1;
    n_chk++;
    if ({rd32, bz32, dz32, q32, r32} !== {1'b1, 1'b0, edz, eq, er}) begin
      n_fail++;
      $display("FAIL %s: rdy=%b busy=%b dz=%b q=%h r=%h expected 1 0 %b %h %h",
               nm, rd32, bz32, dz32, q32, r32, edz, eq, er);
    end
  endtask

  task automatic do_div8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input string nm);
    s8 = 1'b1;
    a8 = a;
    b8 = b;
    @(posedge clk); #1;
    s8 = 1'b0;
    for (int i = 1; i < 9; i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (rd8 !== 1'b0 || bz8 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s early: ready=%b busy=%b expected 0 1", nm, rd8, bz8);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({rd8, bz8, dz8, q8, r8} !== {1'b1, 1'b0, 1'b0, eq, er}) begin
      n_fail++;
      $display("FAIL %s: rdy=%b busy=%b dz=%b q=%h r=%h expected 1 0 0 %h %h",
               nm, rd8, bz8, dz8, q8, r8, eq, er);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bz32, rd32, dz32, q32, r32, bz8, rd8, dz8, q8, r8} !== '0) begin
      n_fail++;
      $display("FAIL reset: b=%b r=%b z=%b q=%h r=%h / %b %b %b %h %h expected 0",
               bz32, rd32, dz32, q32, r32, bz8, rd8, dz8, q8, r8);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_div32(32'd100, 32'd5, 1'b0, 32'd20, 32'd0, 1'b0, "100/5");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({rd32, bz32, dz32, q32, r32} !== {1'b1, 1'b0, 1'b0, 32'd20, 32'd0}) begin
        n_fail++;
        $display("FAIL hold %0d: rdy=%b busy=%b q=%h r=%h expected 1 0 14 0",
                 i, rd32, bz32, q32, r32);
      end
    end
  endtask

  task automatic test_sequence();
    do_div32(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, "10/3");
    do_div32(32'd30, 32'd4, 1'b0, 32'd7, 32'd2, 1'b0, "30/4");
    do_div32(32'd1024, 32'd2, 1'b0, 32'd512, 32'd0, 1'b0, "1024/2");
    do_div32(32'd8, 32'd3, 1'b0, 32'd2, 32'd2, 1'b0, "8/3");
    do_div32(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, "uns F9/2");
  endtask

  task automatic test_div_zero();
    do_div32(32'd7, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd7, 1'b1, "7/0");
    do_div32(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, "9/3 after dz");
  endtask

  task automatic test_busy_ignore();
    s32 = 1'b1;
    a32 = 32'd256;
    b32 = 32'd8;
    @(posedge clk); #1;
    s32 = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
    end
    s32 = 1'b1;
    a32 = 32'd9;
    b32 = 32'd3;
    @(posedge clk); #1;
    s32 = 1'b0;
    for (int i = 6; i < 33; i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (rd32 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore early: ready=%b expected 0", rd32);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({rd32, q32, r32} !== {1'b1, 32'd32, 32'd0}) begin
      n_fail++;
      $display("FAIL ignore: rdy=%b q=%h r=%h expected 1 20 0", rd32, q32, r32);
    end
  endtask

  task automatic test_abort();
    s32 = 1'b1;
    a32 = 32'd256;
    b32 = 32'd8;
    @(posedge clk); #1;
    s32 = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
    end
    s32 = 1'b1;
    a32 = 32'd9;
    b32 = 32'd3;
    @(posedge clk); #1;
    s32 = 1'b0;
    for (int i = 6; i < 10; i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (bz32 !== 1'b1 || rd32 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort busy: busy=%b ready=%b expected 1 0", bz32, rd32);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({bz32, rd32, dz32, q32, r32} !== '0) begin
      n_fail++;
      $display("FAIL abort reset: busy=%b rdy=%b dz=%b q=%h r=%h expected 0",
               bz32, rd32, dz32, q32, r32);
    end
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bz32 !== 1'b0 || rd32 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort idle: busy=%b ready=%b expected 0 0", bz32, rd32);
    end
    do_div32(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, "9/3 after reset");
  endtask

  task automatic test_width8();
    do_div8(8'd255, 8'd16, 8'd15, 8'd15, "w8 255/16");
    do_div8(8'd200, 8'd1, 8'd200, 8'd0, "w8 200/1");
  endtask

  task automatic test_back_to_back();
    logic exp_rd;
    s8 = 1'b1;
    a8 = 8'd100;
    b8 = 8'd7;
    @(posedge clk); #1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      exp_rd = ((k % 10) == 9);
      n_chk++;
      if (rd8 !== exp_rd || (exp_rd && {q8, r8} !== {8'd14, 8'd2})) begin
        n_fail++;
        $display("FAIL b2b edge %0d: rdy=%b q=%h r=%h expected %b 0e 02",
                 k, rd8, q8, r8, exp_rd);
      end
    end
    s8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

`ifdef DIV_ALU_SIGNED_EN
  task automatic test_signed();
    do_div32(-32'sd7, 32'd2, 1'b1, -32'sd3, -32'sd1, 1'b0, "s -7/2");
    do_div32(32'd7, -32'sd2, 1'b1, -32'sd3, 32'd1, 1'b0, "s 7/-2");
    do_div32(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0,
             "s min/-1");
    do_div32(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, "s off F9/2");
  endtask
`endif

  initial begin
    s32 = 1'b0;
    a32 = '0;
    b32 = '0;
    s8 = 1'b0;
    a8 = '0;
    b8 = '0;
`ifdef DIV_ALU_SIGNED_EN
    sg32 = 1'b0;
    sg8 = 1'b0;
`endif
    test_reset();
    test_basic();
    test_sequence();
    test_div_zero();
    test_busy_ignore();
    test_abort();
    test_width8();
    test_back_to_back();
`ifdef DIV_ALU_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_alu_seq.md
Name: div_alu_seq

Overview:
- Parametrised, multi-cycle radix-2 restoring divider; next generation of the fixed 32-bit division ALU.
- Adds a start/ready handshake, a busy indication, a configurable operand width, divide-by-zero detection and optional signed mode.
- Sits beside the datapath ALU and is driven by the control FSM, which launches one division at a time and collects the result on ready.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  launch request; sampled only in IDLE.
- dividend_in  input  WIDTH  dividend; captured on the accepted start.
- divisor_in  input  WIDTH  divisor; captured on the accepted start.
- busy  output  1  high while a division is in progress (CALC, DONE).
- ready  output  1  result valid; level signal.
- quotient_out  output  WIDTH  registered quotient.
- remainder_out  output  WIDTH  registered remainder.
- div_by_zero  output  1  set with ready when the captured divisor was 0.

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - state=IDLE; busy=0, ready=0, div_by_zero=0.
  - quotient_out=0, remainder_out=0; internal registers cleared.
  - Any in-flight division is abandoned.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge E0:
  - Capture operands. Counter=WIDTH. Partial remainder=0.
  - ready=0, busy=1, div_by_zero=0. quotient_out and remainder_out keep their old values.
  - If divisor_in==0, go to DONE with the zero-divide flag latched. Otherwise go to CALC.
- CALC: one step per edge.
  - Shift {rem,quo} left by 1, then trial = rem - divisor (WIDTH+1 bits).
  - If trial is non-negative: rem=trial, quo[0]=1. Otherwise restore, quo[0]=0.
  - Counter decrements; at counter==1 the next state is DONE. This gives exactly WIDTH CALC edges.
- DONE: one edge.
  - Apply sign fix (see Optional Feature) and register the outputs.
  - ready=1, busy=0, go to IDLE.
- Latency, measured from start edge E0:
  - Normal: ready=1 after edge E0+WIDTH+1.
  - Divide by zero: ready=1 after edge E0+1.
- Divide-by-zero result: quotient_out = all ones, remainder_out = dividend_in, div_by_zero=1.
- Hold: ready, div_by_zero and the outputs hold indefinitely until the next accepted start. That start clears ready and div_by_zero on the same edge.
- start while busy=1 (CALC or DONE): ignored, with no queuing.
- start held high continuously: a new division launches on every IDLE edge. Back-to-back spacing is WIDTH+2 edges.
- Operand inputs are don't-care except on the accepted start edge.

Optional Feature:
- Macro: DIV_ALU_SIGNED_EN.
- Defined:
  - Adds port signed_in (input, 1), sampled with start. When it is 1, operands are two's complement.
  - CALC operates on magnitudes.
  - At DONE, the quotient is negated if the operand signs differ (truncation toward zero), and the remainder takes the dividend's sign.
  - Most-negative / -1 returns quotient = most-negative and remainder 0, with no flag.
  - Divide-by-zero result is unchanged (remainder = raw dividend).
- Undefined: no signed_in port; all operands are unsigned; no sign-fix logic.

Test Plan:
- WIDTH=32, reset released, start with 100/5 at E0 -> busy=1 from E0; ready=1 after E0+33 with quotient 20, remainder 0, div_by_zero 0; values hold for 10 idle cycles.
- WIDTH=32, sequential 10/3, 30/4, 1024/2, 8/3 -> 3 r1, 7 r2, 512 r0, 2 r2; ready drops on each new start edge.
- WIDTH=32, 7/0 -> ready after E0+1, quotient 0xFFFFFFFF, remainder 7, div_by_zero 1; a following 9/3 clears the flag and returns 3 r0.
- WIDTH=32, start 256/8, second start 9/3 pulsed at E0+5, reset pulsed low at E0+10 -> second start ignored; after reset all outputs 0 and state IDLE; a fresh 9/3 returns 3 r0 after 33 edges.
- WIDTH=8, 255/16 -> 15 r15 after E0+9; 200/1 -> 200 r0; start held high -> results every 10 edges.
- DIV_ALU_SIGNED_EN defined, WIDTH=32, signed_in=1:
  - -7/2 -> quotient -3, remainder -1.
  - 7/-2 -> quotient -3, remainder 1.
  - 0x80000000/-1 -> quotient 0x80000000, remainder 0.
  - signed_in=0 with 0xFFFFFFF9/2 -> quotient 0x7FFFFFFC, remainder 1.
